// File: rtl/seg_scan_mux_if.sv
// Bundle between the digit register file and the seven-segment scanner.
// digits/en_mask are level inputs; segment, anode and debug outputs are registered by the scanner.
interface seg_scan_mux_if;
  // No valid/ready: every signal is a continuously valid level, sampled or driven on each clk edge.
  logic [31:0] digits;
  logic [7:0]  en_mask;
  logic        a, b, c, d, e, f, g;
  logic        an0, an1, an2, an3, an4, an5, an6, an7;
  logic        frame_tick;
  logic [2:0]  dbg_idx;
  logic        dbg_show;

  modport master (
    output digits, en_mask,
    input  a, b, c, d, e, f, g,
    input  an0, an1, an2, an3, an4, an5, an6, an7,
    input  frame_tick, dbg_idx, dbg_show
  );

  modport slave (
    input  digits, en_mask,
    output a, b, c, d, e, f, g,
    output an0, an1, an2, an3, an4, an5, an6, an7,
    output frame_tick, dbg_idx, dbg_show
  );
endinterface

// File: rtl/seg_scan_mux.sv
// 8-digit time-multiplexed seven-segment scanner with per-slot blanking and a frame marker.
// Optional leading-zero suppression is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_mux #(
    parameter int DIV       = 8,
    parameter int BLANK_CYC = 2
) (
    input logic       clk,
    input logic       reset,
    seg_scan_mux_if.slave bus
);

    localparam int CW = $clog2(DIV);

    typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [31:0]   shadow, shadow_nxt;
    logic          cnt_wrap, frame_wrap, show;
    logic [3:0]    nib;
    logic [7:0]    lz;
    logic [7:0]    an_r;
    logic [6:0]    seg_r;
    logic          tick_r;
    phase_t        phase;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b0000001;
            4'h1: decode = 7'b1001111;
            4'h2: decode = 7'b0010010;
            4'h3: decode = 7'b0000110;
            4'h4: decode = 7'b1001100;
            4'h5: decode = 7'b0100100;
            4'h6: decode = 7'b0100000;
            4'h7: decode = 7'b0001111;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0000100;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b1100000;
            4'hC: decode = 7'b0110001;
            4'hD: decode = 7'b1000010;
            4'hE: decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    // Outputs are computed from the post-edge count so they line up with the new cnt/idx.
    always_comb begin
        cnt_wrap   = (cnt == CW'(DIV - 1));
        cnt_nxt    = cnt_wrap ? '0 : cnt + CW'(1);
        idx_nxt    = cnt_wrap ? idx + 3'd1 : idx;
        frame_wrap = cnt_wrap && (idx == 3'd7);
        shadow_nxt = frame_wrap ? bus.digits : shadow;
        nib        = shadow_nxt[{idx_nxt, 2'b00} +: 4];
`ifdef SEG_LZ_BLANK_EN
        // lz[i]: nibbles i..7 are all zero; digit 0 is always shown.
        lz = '0;
        for (int i = 7; i >= 1; i--) begin
            lz[i] = (shadow_nxt[i*4 +: 4] == 4'h0) && ((i == 7) ? 1'b1 : lz[i+1]);
        end
`else
        lz = '0;
`endif
        show = (cnt_nxt >= CW'(BLANK_CYC)) && bus.en_mask[idx_nxt] && !lz[idx_nxt];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= 3'd0;
            shadow <= bus.digits;
            an_r   <= 8'hFF;
            seg_r  <= 7'h7F;
            tick_r <= 1'b0;
            phase  <= PH_BLANK;
        end else begin
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shadow <= shadow_nxt;
            tick_r <= frame_wrap;
            phase  <= show ? PH_SHOW : PH_BLANK;
            an_r   <= show ? ~(8'b1 << idx_nxt) : 8'hFF;
            seg_r  <= show ? decode(nib) : 7'h7F;
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_r;
    assign {bus.an7, bus.an6, bus.an5, bus.an4, bus.an3, bus.an2, bus.an1, bus.an0} = an_r;
    assign bus.frame_tick = tick_r;
    assign bus.dbg_idx    = idx;
    assign bus.dbg_show   = (phase == PH_SHOW);

endmodule
